opl3_reg_bus_arbiter: RTL

Shares the OPL3 register-file bus (cs/rd/wr/bank_select/address/data_in/data_out/rd_valid) between two requesters: port 0 is the host/CPU bridge and port 1 is the hardware playback sequencer.
- Serialises requests and enforces a minimum idle gap after every register write.
- Bounds reads with a timeout and returns per-requester responses.
- Sits between the requesters and the register file, inside the OPL3 top level.

---
 rtl/opl3_reg_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/opl3_reg_bus_arbiter.sv
// Two-requester arbiter for the OPL3 register-file bus.
// Port 0 is the host bridge and port 1 is the playback sequencer.
// Only one transaction is in flight at a time. Every write is followed by
// a forced idle gap, and every read is bounded by a timeout.
// Optional build macro: OPL3_ARB_FIXED_PRIO_EN. When it is defined,
// requester 0 always wins a tie and the round-robin pointer is removed.
module opl3_reg_bus_arbiter #(
    parameter int WR_GAP_CYCLES          = 8,
    parameter int RD_TIMEOUT             = 64,
    parameter int REG_FILE_ADDRESS_WIDTH = 8,
    parameter int REG_FILE_DATA_WIDTH    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [1:0]                             req_valid,
    output logic [1:0]                             req_ready,
    input  logic [1:0]                             req_wr,
    input  logic [1:0]                             req_bank,
    input  logic [1:0][REG_FILE_ADDRESS_WIDTH-1:0] req_addr,
    input  logic [1:0][REG_FILE_DATA_WIDTH-1:0]    req_wdata,
    output logic [1:0]                             rsp_valid,
    output logic [REG_FILE_DATA_WIDTH-1:0]         rsp_rdata,
    output logic                                   rsp_err,
    output logic                                   cs,
    output logic                                   rd,
    output logic                                   wr,
    output logic                                   bank_select,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0]      address,
    output logic [REG_FILE_DATA_WIDTH-1:0]         data_in,
    input  logic [REG_FILE_DATA_WIDTH-1:0]         data_out,
    input  logic                                   rd_valid
);

    localparam int GW = (WR_GAP_CYCLES > 1) ? $clog2(WR_GAP_CYCLES) : 1;
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_GAP} state_t;

    state_t                            state, state_nxt;
    logic                              win_id;
    logic                              accept;
    logic                              lat_bank;
    logic                              lat_id;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] lat_addr;
    logic [REG_FILE_DATA_WIDTH-1:0]    lat_wdata;
    logic [GW-1:0]                     gap_cnt;
    logic [TW-1:0]                     to_cnt;
    logic                              gap_last;
    logic                              to_last;

    assign accept   = (state == S_IDLE) && (|req_valid);
    assign gap_last = (gap_cnt == GW'(WR_GAP_CYCLES - 1));
    assign to_last  = (to_cnt == TW'(RD_TIMEOUT - 1));

`ifdef OPL3_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    always_comb win_id = ~req_valid[0];
`else
    logic last_id;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        if (&req_valid) win_id = ~last_id;
        else            win_id = ~req_valid[0];
    end

    // Remember the last grant. The reset value of 1 hands the first tie to requester 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    last_id <= 1'b1;
        else if (accept) last_id <= win_id;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state and bus/handshake outputs.
    // Outputs decode straight from the state, so an asynchronous reset drops the strobes at once.
    always_comb begin
        state_nxt   = state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        cs          = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        bank_select = 1'b0;
        address     = '0;
        data_in     = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    req_ready[win_id] = 1'b1;
                    state_nxt         = req_wr[win_id] ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                cs                = 1'b1;
                wr                = 1'b1;
                bank_select       = lat_bank;
                address           = lat_addr;
                data_in           = lat_wdata;
                rsp_valid[lat_id] = 1'b1;
                state_nxt         = (WR_GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_last) state_nxt = S_IDLE;
            end
            S_READ: begin
                cs          = 1'b1;
                rd          = 1'b1;
                bank_select = lat_bank;
                address     = lat_addr;
                if (rd_valid || to_last) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid[lat_id] = 1'b1;
                state_nxt         = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, gap and timeout counters, and the held response data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_bank  <= 1'b0;
            lat_id    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_bank  <= req_bank[win_id];
                lat_id    <= win_id;
                lat_addr  <= req_addr[win_id];
                lat_wdata <= req_wdata[win_id];
                // A write response always reports no error. The read data is left as it was.
                if (req_wr[win_id]) rsp_err <= 1'b0;
            end
            if (state == S_READ) begin
                // Read data wins over a timeout that lands in the same cycle.
                if (rd_valid) begin
                    rsp_rdata <= data_out;
                    rsp_err   <= 1'b0;
                end else if (to_last) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            if (state == S_GAP && !gap_last) gap_cnt <= gap_cnt + GW'(1);
            else                             gap_cnt <= '0;
            if (state == S_READ && !(rd_valid || to_last)) to_cnt <= to_cnt + TW'(1);
            else                                           to_cnt <= '0;
        end
    end

endmodule
